// File: rtl/rr_grant_ctrl.sv
// rr_grant_ctrl: eight-way round-robin owner selection for one shared resource.
// Drives EN/select of the downstream 3-to-8 one-hot decoder. An owner keeps the
// grant until DONE or its request drops. With ARB_TIMEOUT_EN defined, a hold
// timer also forces release after MAX_HOLD grant cycles and pulses TIMEOUT.
// Every release is followed by exactly one gap cycle with the decoder disabled.
module rr_grant_ctrl #(
   parameter int MAX_HOLD = 16
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [7:0] REQ,
   input  logic       DONE,
   output logic       GNT_EN,
   output logic [2:0] GNT_IDX,
   output logic       TIMEOUT
);

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

   state_t     state_q;
   logic [2:0] ptr_q;
   logic       gnt_en_q;
   logic [2:0] gnt_idx_q;
   logic       timeout_q;

   logic [2:0] win_idx_d;
   logic       win_vld_d;
   logic       rel_user_d;
   logic       hold_exp_d;
   logic       release_d;

   // Reject hold limits the counter width cannot represent.
   if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
      $error("rr_grant_ctrl: MAX_HOLD must be within 2..256");
   end

   // First requester at or after PTR in circular order; scanning from the far end
   // down lets the nearest set bit overwrite the others.
   always_comb begin
      win_vld_d = 1'b0;
      win_idx_d = ptr_q;
      for (int i = 7; i >= 0; i--) begin
         if (REQ[ptr_q + 3'(i)]) begin
            win_vld_d = 1'b1;
            win_idx_d = ptr_q + 3'(i);
         end
      end
   end

   // Owner-initiated release; DONE only matters while a grant is active.
   assign rel_user_d = DONE | ~REQ[gnt_idx_q];
   assign release_d  = rel_user_d | hold_exp_d;

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(MAX_HOLD);

   logic [CW-1:0] hold_cnt_q;

   assign hold_exp_d = (state_q == S_GRANT) && (hold_cnt_q == CW'(MAX_HOLD - 1));

   // Hold timer: zero outside GRANT so every new grant starts from 0.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         hold_cnt_q <= '0;
      end else if (state_q != S_GRANT) begin
         hold_cnt_q <= '0;
      end else if (!release_d) begin
         hold_cnt_q <= hold_cnt_q + CW'(1);
      end
   end
`else
   assign hold_exp_d = 1'b0;
`endif

   // Arbitration FSM with registered decoder controls and timeout pulse.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= S_IDLE;
         ptr_q     <= 3'd0;
         gnt_en_q  <= 1'b0;
         gnt_idx_q <= 3'd0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            S_IDLE, S_GAP: begin
               if (win_vld_d) begin
                  gnt_en_q  <= 1'b1;
                  gnt_idx_q <= win_idx_d;
                  state_q   <= S_GRANT;
               end else begin
                  state_q   <= S_IDLE;
               end
            end
            S_GRANT: begin
               if (release_d) begin
                  gnt_en_q  <= 1'b0;
                  ptr_q     <= gnt_idx_q + 3'd1;
                  // Forced release is only reported when the owner did not let go itself.
                  timeout_q <= hold_exp_d & ~rel_user_d;
                  state_q   <= S_GAP;
               end
            end
            default: begin
               gnt_en_q <= 1'b0;
               state_q  <= S_IDLE;
            end
         endcase
      end
   end

   assign GNT_EN  = gnt_en_q;
   assign GNT_IDX = gnt_idx_q;
   assign TIMEOUT = timeout_q;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Bench for rr_grant_ctrl: expected owners are queued when stimulus is applied
// and compared when the grant shows up. Outputs sampled 1 time unit after the edge.
module tb_rr_grant_ctrl;

   localparam int MAX_HOLD = 16;
`ifdef ARB_TIMEOUT_EN
   localparam int HOLD_CAP = 40;
   localparam int EXP_HOLD = MAX_HOLD;
`else
   localparam int HOLD_CAP = 40;
   localparam int EXP_HOLD = HOLD_CAP;
`endif

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic       done;
   logic       gnt_en;
   logic [2:0] gnt_idx;
   logic       timeout;

   int checks = 0;
   int errors = 0;
   int exp_q[$];

   rr_grant_ctrl #(.MAX_HOLD(MAX_HOLD)) dut (
      .CLK     (clk),
      .RST_N   (rst_n),
      .REQ     (req),
      .DONE    (done),
      .GNT_EN  (gnt_en),
      .GNT_IDX (gnt_idx),
      .TIMEOUT (timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for GNT_EN, then pop the expected owner and compare.
   task automatic expect_grant(input string name, input int max_cycles);
      int n;
      int e;
      n = 0;
      while (gnt_en !== 1'b1 && n < max_cycles) begin
         tick();
         n++;
      end
      e = exp_q.pop_front();
      checks++;
      if (gnt_en !== 1'b1) begin
         errors++;
         $display("FAIL %s: no grant within %0d cycles, expected owner %0d", name, max_cycles, e);
      end else if (gnt_idx !== 3'(e)) begin
         errors++;
         $display("FAIL %s: owner got %0d expected %0d", name, gnt_idx, e);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = 8'hFF;
      done  = 1'b0;
      tick();
      tick();
      checks++;
      if (gnt_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_en: got %0b expected 0", gnt_en);
      end
      checks++;
      if (gnt_idx !== 3'd0) begin
         errors++;
         $display("FAIL reset_idx: got %0d expected 0", gnt_idx);
      end
      checks++;
      if (timeout !== 1'b0) begin
         errors++;
         $display("FAIL reset_timeout: got %0b expected 0", timeout);
      end
      rst_n = 1'b1;
      exp_q.push_back(0);
      tick();
      // Exactly one edge after reset release: strict latency check.
      expect_grant("reset_first_grant", 0);
   endtask

   task automatic test_rotation();
      int owner;
      owner = 0;
      for (int k = 0; k < 8; k++) begin
         done = 1'b1;
         tick();
         done = 1'b0;
         checks++;
         if (gnt_en !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL rotation_gap: en=%0b to=%0b expected 0/0 after owner %0d", gnt_en, timeout, owner);
         end
         owner = (owner + 1) % 8;
         exp_q.push_back(owner);
         tick();
         expect_grant("rotation_next", 0);
      end
   endtask

   task automatic test_wrap_skip();
      // Move ownership to 6.
      req  = 8'h40;
      done = 1'b1;
      tick();
      done = 1'b0;
      exp_q.push_back(6);
      tick();
      expect_grant("wrap_owner6", 0);
      // Owner 6 releases; PTR becomes 7, only 0 and 2 request.
      req  = 8'b0000_0101;
      done = 1'b1;
      tick();
      done = 1'b0;
      exp_q.push_back(0);
      tick();
      expect_grant("wrap_to_0", 0);
      done = 1'b1;
      tick();
      done = 1'b0;
      exp_q.push_back(2);
      tick();
      expect_grant("skip_to_2", 0);
   endtask

   task automatic test_req_drop();
      req  = 8'h08;
      done = 1'b1;
      tick();
      done = 1'b0;
      exp_q.push_back(3);
      tick();
      expect_grant("drop_owner3", 0);
      // Other requesters toggling must not disturb owner 3.
      for (int k = 0; k < 3; k++) begin
         req = (k % 2 == 0) ? 8'hFF : 8'h08;
         tick();
         checks++;
         if (gnt_en !== 1'b1 || gnt_idx !== 3'd3) begin
            errors++;
            $display("FAIL hold_owner3: en=%0b idx=%0d expected 1/3", gnt_en, gnt_idx);
         end
      end
      // Drop REQ[3]; 0,1,5 pending, search from 4 must pick 5.
      req = 8'h23;
      tick();
      checks++;
      if (gnt_en !== 1'b0 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL drop_release: en=%0b to=%0b expected 0/0", gnt_en, timeout);
      end
      exp_q.push_back(5);
      tick();
      expect_grant("drop_next_from_4", 0);
   endtask

   task automatic test_timeout();
      int cnt;
      int to_seen;
      // Return to IDLE (PTR=6), then grant owner 5 alone.
      req = 8'h00;
      tick();
      tick();
      tick();
      checks++;
      if (gnt_en !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_grant: en=%0b expected 0", gnt_en);
      end
      req = 8'h20;
      exp_q.push_back(5);
      tick();
      expect_grant("timeout_owner5", 0);
      cnt = 0;
      to_seen = 0;
      while (gnt_en === 1'b1 && cnt < HOLD_CAP) begin
         cnt++;
         if (timeout === 1'b1) to_seen++;
         tick();
      end
      checks++;
      if (cnt !== EXP_HOLD) begin
         errors++;
         $display("FAIL hold_length: got %0d cycles expected %0d", cnt, EXP_HOLD);
      end
      checks++;
      if (to_seen !== 0) begin
         errors++;
         $display("FAIL timeout_early: got %0d pulses during grant expected 0", to_seen);
      end
`ifdef ARB_TIMEOUT_EN
      checks++;
      if (gnt_en !== 1'b0 || timeout !== 1'b1) begin
         errors++;
         $display("FAIL timeout_pulse: en=%0b to=%0b expected 0/1", gnt_en, timeout);
      end
      exp_q.push_back(5);
      tick();
      checks++;
      if (timeout !== 1'b0) begin
         errors++;
         $display("FAIL timeout_width: to=%0b expected 0", timeout);
      end
      expect_grant("timeout_regrant", 0);
`else
      checks++;
      if (gnt_en !== 1'b1 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL no_timeout_hold: en=%0b to=%0b expected 1/0", gnt_en, timeout);
      end
`endif
   endtask

   task automatic test_async_reset();
      req = 8'h21;
      tick();
      checks++;
      if (gnt_en !== 1'b1 || gnt_idx !== 3'd5) begin
         errors++;
         $display("FAIL pre_reset_grant: en=%0b idx=%0d expected 1/5", gnt_en, gnt_idx);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (gnt_en !== 1'b0 || gnt_idx !== 3'd0) begin
         errors++;
         $display("FAIL async_reset_drop: en=%0b idx=%0d expected 0/0", gnt_en, gnt_idx);
      end
      tick();
      tick();
      rst_n = 1'b1;
      exp_q.push_back(0);
      tick();
      expect_grant("post_reset_owner0", 0);
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 8'h00;
      done  = 1'b0;
      test_reset();
      test_rotation();
      test_wrap_skip();
      test_req_drop();
      test_timeout();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_grant_ctrl.md
# rr_grant_ctrl

Round-robin scheduler that shares one downstream resource among eight requesters on the Basys3 fabric. It selects one owner at a time and drives the enable and 3-bit select of the existing 3-to-8 one-hot decoder, whose output forms the per-requester grant lines. Ownership is held until the owner signals done, drops its request, or, optionally, a hold timeout expires. A guaranteed one-cycle break-before-make gap separates consecutive owners.

## Interface
- MAX_HOLD, 16: maximum cycles one owner may hold the grant, used only when the timeout is compiled in. Legal range is 2..256.
- CLK  input  1  system clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous, active-low reset. Assertion acts immediately; deassertion is synchronous to CLK.
- REQ  input  8  request vector; bit n is requester n, level-sensitive.
- DONE  input  1  the current owner releases the resource; ignored while GNT_EN=0.
- GNT_EN  output  1  registered; drives the decoder EN.
- GNT_IDX  output  3  registered index of the current owner; drives the decoder I.
- TIMEOUT  output  1  registered one-cycle pulse on a forced release.

## Operation
- States: IDLE, GRANT, GAP. State encoding is left to the implementation.
- Pointer PTR (3 bits) holds the highest-priority index. The search order is PTR, PTR+1, …, 7, 0, …, PTR-1, modulo 8.
- IDLE:
  - If REQ≠0: load GNT_IDX with the first set bit in search order, set GNT_EN=1, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT: release occurs when DONE=1, or REQ[GNT_IDX]=0, or (with the timeout compiled in) HOLD_CNT=MAX_HOLD-1. On release:
  - GNT_EN←0.
  - PTR←GNT_IDX+1, wrapping 7→0.
  - Go to GAP.
  - GNT_IDX keeps its value while GNT_EN=0.
- GAP: lasts exactly one cycle. On its exit edge, run the IDLE arbitration against the already-updated PTR. Go to GRANT if any request is pending, otherwise go to IDLE.
- Simultaneous release causes (DONE together with REQ drop and/or timeout) count as a single release. TIMEOUT pulses only if neither DONE nor REQ[GNT_IDX]=0 is present that cycle.
- Other requesters' REQ changes during GRANT have no effect on the current owner.
- REQ=8'h00 at arbitration means no grant is issued and PTR is unchanged.
- Reset values: state=IDLE, PTR=0, GNT_EN=0, GNT_IDX=3'd0, TIMEOUT=0, HOLD_CNT=0.
- Reset during GRANT forces GNT_EN low asynchronously with no gap cycle. After reset, requester 0 has top priority.

## Timing
- Grant latency: REQ is sampled on edge k in IDLE; GNT_EN and GNT_IDX are valid after edge k. There is no combinational path from REQ or DONE to any output.
- Release latency: DONE is sampled on edge k; GNT_EN goes low after edge k.
- Back-to-back ownership: GNT_EN is low for exactly one cycle (GAP) between owners. The minimum grant length is one cycle.
- HOLD_CNT is $clog2(MAX_HOLD) bits wide. It clears to 0 on every grant edge and increments each GRANT cycle without release. A never-releasing owner therefore gets exactly MAX_HOLD cycles of GNT_EN=1.
- TIMEOUT goes high in the same cycle that GNT_EN first reads low, and lasts exactly one cycle.

## Configuration
- ARB_TIMEOUT_EN defined: HOLD_CNT and the forced release are present, and TIMEOUT behaves as specified above.
- ARB_TIMEOUT_EN undefined:
  - No counter logic is built; MAX_HOLD is ignored.
  - TIMEOUT is tied to 0.
  - The grant is held until DONE or until REQ[GNT_IDX] drops.

## Test plan
- Reset behaviour:
  - Stimulus: hold RST_N=0 with REQ=8'hFF; release reset.
  - Required response: outputs are 0 during reset. One cycle after release, GNT_EN=1 and GNT_IDX=0.
- Rotation:
  - Stimulus: REQ=8'hFF held, DONE pulsed once during each grant.
  - Required response: GNT_IDX sequence is 0,1,…,7,0. GNT_EN is low for exactly one cycle between grants.
- Wrap and skip:
  - Stimulus: PTR=7 after owner 6 releases, with REQ=8'b0000_0101.
  - Required response: GNT_IDX=0. After DONE, GNT_IDX=2.
- Request drop:
  - Stimulus: owner 3 deasserts REQ[3] with DONE=0.
  - Required response: GNT_EN goes low on the next edge, TIMEOUT stays 0, and the next search starts from index 4.
- Timeout (ARB_TIMEOUT_EN defined, MAX_HOLD=16):
  - Stimulus: owner 5 never releases, with REQ=8'h20 held.
  - Required response: exactly 16 cycles of GNT_EN=1, then TIMEOUT pulses once, then the gap, then owner 5 is re-granted.
  - Without the macro: GNT_EN stays high indefinitely.
- Asynchronous reset mid-grant:
  - Stimulus: assert RST_N=0 between clock edges while GNT_EN=1.
  - Required response: GNT_EN drops immediately. After release, requester 0 wins if REQ[0]=1.
